// File: rtl/par_serial_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
//   IDLE_CODE     : comma/idle symbol sent whenever no user data is loaded
//   DEFAULT_WIDTH : default parallel word width
//   tx_state_e    : transmitter FSM states (SYNC = alignment preamble, RUN = normal traffic)
package par_serial_tx_pkg;

   localparam logic [7:0] IDLE_CODE     = 8'hBC;
   localparam int         DEFAULT_WIDTH = 8;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } tx_state_e;

endpackage

// File: rtl/par_serial_tx_piso.sv
// Parallel-in / serial-out shift register.
//   clk        : bit clock
//   rst        : asynchronous active-low reset, clears the register
//   enb        : register holds when low
//   load       : on an enabled edge, capture data instead of shifting
//   data       : word to capture
//   serial_out : MSB of the register, combinational from the register
module piso_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic             serial_out
);

   logic [WIDTH-1:0] sr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= '0;
      end else if (enb) begin
         if (load) begin
            sr_q <= data;
         end else begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign serial_out = sr_q[WIDTH-1];

endmodule

// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmitter, MSB first, one bit per enabled bit-clock edge.
// After reset it sends SYNC_WORDS idle words so the far end can align, then
// accepts user words; idle symbols fill every slot with no data offered.
//   clk, rst, enb  : bit clock, async active-low reset, global enable
//   data_in        : parallel word from upstream
//   valid_in       : data_in valid
//   ready_out      : word accepted this cycle when valid_in && ready_out
//   serial_out     : serial stream
//   word_start     : serial_out carries the MSB of a word
//   sending_data   : current word is user data (low for idle)
//   state_dbg      : current FSM state
//
// Handshake: valid/ready. A transfer happens on the rising edge where both
// valid_in and ready_out are high. Once valid_in is raised, upstream keeps
// valid_in and data_in stable until that transfer. ready_out is only high on
// the load edge of a word slot while running and enabled.
module par_serial_tx
   import par_serial_tx_pkg::*;
#(
   parameter int               WIDTH      = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] IDLE       = WIDTH'(IDLE_CODE),
   parameter int               SYNC_WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             serial_out,
   output logic             word_start,
   output logic             sending_data,
   output tx_state_e        state_dbg
);

   localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_MAX   = CW'(WIDTH - 1);
   localparam logic [3:0]     SYNC_LAST = 4'(SYNC_WORDS - 1);

   tx_state_e        state_q, state_nxt;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       sync_cnt_q, sync_cnt_nxt;
   logic             sending_q, sending_nxt;
   logic             loaded_once_q;
   logic             load_edge;
   logic [WIDTH-1:0] load_word;

   // Every WIDTH-th enabled edge starts a new word slot.
   assign load_edge = enb && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SYNC;
      end else if (enb) begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      sync_cnt_nxt = sync_cnt_q;
      sending_nxt  = sending_q;
      load_word    = IDLE;
      ready_out    = 1'b0;
      case (state_q)
         SYNC: begin
            if (load_edge) begin
               sync_cnt_nxt = sync_cnt_q + 4'd1;
               sending_nxt  = 1'b0;
               if (sync_cnt_q == SYNC_LAST) begin
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            ready_out = load_edge;
            if (load_edge) begin
               if (valid_in) begin
                  load_word   = data_in;
                  sending_nxt = 1'b1;
               end else begin
                  sending_nxt = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q         <= CNT_MAX;
         sync_cnt_q    <= 4'd0;
         sending_q     <= 1'b0;
         loaded_once_q <= 1'b0;
      end else if (enb) begin
         cnt_q      <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
         sync_cnt_q <= sync_cnt_nxt;
         sending_q  <= sending_nxt;
         if (load_edge) begin
            loaded_once_q <= 1'b1;
         end
      end
   end

   piso_shift #(
      .WIDTH(WIDTH)
   ) u_piso (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .load      (load_edge),
      .data      (load_word),
      .serial_out(serial_out)
   );

   // Count is 0 exactly while the MSB of the last loaded word is on the line.
   assign word_start   = (cnt_q == '0) && loaded_once_q;
   assign sending_data = sending_q;
   assign state_dbg    = state_q;

endmodule
